// File: rtl/dbus_uncached_responder_if.sv
// Core data-bus and memory-side signals of the uncached responder.
// The slave modport is the responder's view; the master modport is the
// environment (core data port plus memory/AXI bridge).
interface dbus_uncached_responder_if;
    // core side
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [2:0]  size;
    logic [3:0]  offset;
    logic [7:0]  index;
    logic [19:0] tag;
    logic [31:0] wdata;
    logic        iscache;
    logic        tlb_ex;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    // memory side
    logic        mem_req;
    logic        mem_wr;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  req, wr, wstrb, size, offset, index, tag, wdata, iscache, tlb_ex,
        output addr_ok, data_ok, rdata,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output req, wr, wstrb, size, offset, index, tag, wdata, iscache, tlb_ex,
        input  addr_ok, data_ok, rdata,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/dbus_uncached_responder.sv
// Uncached data-bus responder: queues core load/store requests in order and
// issues each one as a single transaction on the memory-side addr_ok/data_ok
// port. Requests carrying a TLB exception are answered with rdata = 0 and
// never reach memory. Only one memory transaction is outstanding at a time.
module dbus_uncached_responder #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    dbus_uncached_responder_if.slave bus_io
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic        wr;
        logic        tlb_ex;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [2:0]  size;
        logic [31:0] wdata;
    } entry_t;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    entry_t           fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic             data_ok_q, data_ok_d;
    logic [31:0]      rdata_q, rdata_d;

    entry_t head;
    entry_t push_entry;
    logic   head_valid;
    logic   push;
    logic   pop;

    // iscache is deliberately ignored: every access is uncached.
    logic unused_iscache;
    assign unused_iscache = bus_io.iscache;

    // Acceptance uses the registered occupancy only, so a same-cycle pop
    // never makes room for a push into a full queue. The reset term keeps
    // addr_ok low while reset is held even if req is already up.
    assign push           = bus_io.req && (count_q != FULL_CNT) && !reset;
    assign bus_io.addr_ok = push;
    assign head_valid     = (count_q != '0);
    assign head           = fifo_q[rd_ptr_q];
    assign push_entry     = '{wr:     bus_io.wr,
                              tlb_ex: bus_io.tlb_ex,
                              addr:   {bus_io.tag, bus_io.index, bus_io.offset},
                              wstrb:  bus_io.wstrb,
                              size:   bus_io.size,
                              wdata:  bus_io.wdata};
    assign bus_io.data_ok = data_ok_q;
    assign bus_io.rdata   = rdata_q;

    // Queue storage: written on accept; pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    // Pointer and occupancy next-state; pointers wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Queue pointers, occupancy and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave IDLE once memory takes the address, return on data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (head_valid && !head.tlb_ex && bus_io.mem_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus_io.mem_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: memory request from the head entry, pop and response.
    // The head stays queued until its response, so mem_* fields hold steady
    // while waiting for mem_addr_ok.
    always_comb begin
        bus_io.mem_req   = 1'b0;
        bus_io.mem_wr    = 1'b0;
        bus_io.mem_size  = '0;
        bus_io.mem_addr  = '0;
        bus_io.mem_wstrb = '0;
        bus_io.mem_wdata = '0;
        pop              = 1'b0;
        data_ok_d        = 1'b0;
        rdata_d          = '0;
        case (state_q)
            ST_IDLE: begin
                if (head_valid) begin
                    if (head.tlb_ex) begin
                        pop       = 1'b1;
                        data_ok_d = 1'b1;
                    end else begin
                        bus_io.mem_req   = 1'b1;
                        bus_io.mem_wr    = head.wr;
                        bus_io.mem_size  = head.size;
                        bus_io.mem_addr  = head.addr;
                        bus_io.mem_wstrb = head.wr ? head.wstrb : 4'b0000;
                        bus_io.mem_wdata = head.wdata;
                    end
                end
            end
            ST_WAIT: begin
                if (bus_io.mem_data_ok) begin
                    pop       = 1'b1;
                    data_ok_d = 1'b1;
                    rdata_d   = head.wr ? 32'h0 : bus_io.mem_rdata;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dbus_uncached_responder.sv
// Scoreboard bench for dbus_uncached_responder: stimulus pushes expected
// responses and expected memory transactions into queues; a memory model
// and a response monitor pop and compare independently.
module tb_dbus_uncached_responder;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // memory model delay ranges
    int a_min = 0, a_max = 0, d_min = 0, d_max = 0;

    typedef struct {
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] ret;
        int          acc;
        int          hs_lat;
    } plan_t;

    resp_t exp_q[$];
    plan_t plan_q[$];

    dbus_uncached_responder_if bus();

    dbus_uncached_responder #(.DEPTH(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    // Issue one request; call at a negedge, returns at a negedge.
    task automatic issue(input logic w, input logic tlb, input logic [31:0] a,
                         input logic [3:0] st, input logic [2:0] sz, input logic [31:0] wd,
                         input logic [31:0] ret, input int lat, input int hs, output int acc);
        int  tries = 0;
        bit  done  = 0;
        resp_t r;
        plan_t p;
        bus.req = 1'b1;
        bus.wr = w;
        bus.tlb_ex = tlb;
        {bus.tag, bus.index, bus.offset} = a;
        bus.wstrb = st;
        bus.size = sz;
        bus.wdata = wd;
        bus.iscache = 1'($urandom);
        acc = -1;
        while (!done) begin
            #1;
            if (bus.addr_ok) begin
                acc = cyc;
                done = 1;
                r.rdata = (w || tlb) ? 32'h0 : ret;
                r.acc = cyc;
                r.lat = lat;
                exp_q.push_back(r);
                if (!tlb) begin
                    p.wr = w; p.size = sz; p.addr = a;
                    p.wstrb = w ? st : 4'b0000;
                    p.wdata = wd; p.ret = ret; p.acc = cyc; p.hs_lat = hs;
                    plan_q.push_back(p);
                end
            end else if (tries++ > 400) begin
                total++; bad++;
                $display("FAIL accept_timeout: got addr_ok=0 for 400 cycles required 1");
                done = 1;
            end
            @(negedge clk);
        end
        bus.req = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || plan_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size() + plan_q.size()), 0);
        repeat (3) @(negedge clk);
    endtask

    // memory model
    initial begin
        int   wcnt = 0, dcnt = 0;
        bit   seen = 0, mst = 0, hold_bad = 0;
        logic [31:0] ret = 0;
        logic [71:0] cap = 0, snap;
        plan_t p;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            snap = {bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata};
            if (reset) begin
                mst = 0; seen = 0;
                bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'h0;
            end else if (mst) begin
                bus.mem_addr_ok = 1'b0;
                if (dcnt == 0) begin
                    bus.mem_data_ok = 1'b1; bus.mem_rdata = ret; mst = 0;
                end else begin
                    dcnt--; bus.mem_data_ok = 1'b0; bus.mem_rdata = $urandom;
                end
            end else begin
                bus.mem_data_ok = 1'b0;
                bus.mem_rdata = $urandom;
                if (bus.mem_req) begin
                    if (!seen) begin
                        seen = 1; cap = snap; hold_bad = 0;
                        wcnt = $urandom_range(a_max, a_min);
                    end else if (snap != cap) begin
                        hold_bad = 1;
                    end
                    if (wcnt == 0) begin
                        bus.mem_addr_ok = 1'b1;
                        seen = 0; mst = 1;
                        dcnt = $urandom_range(d_max, d_min);
                        chk("mem_hold_stable", 32'(hold_bad), 0);
                        if (plan_q.size() == 0) begin
                            total++; bad++; ret = 32'h0;
                            $display("FAIL mem_unexpected: got mem_req addr=%h required none", bus.mem_addr);
                        end else begin
                            p = plan_q.pop_front();
                            chk("mem_wr", 32'(bus.mem_wr), 32'(p.wr));
                            chk("mem_size", 32'(bus.mem_size), 32'(p.size));
                            chk("mem_addr", bus.mem_addr, p.addr);
                            chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(p.wstrb));
                            chk("mem_wdata", bus.mem_wdata, p.wdata);
                            ret = p.ret;
                            if (p.hs_lat > 0) chk("mem_req_latency", cyc - p.acc, p.hs_lat);
                        end
                    end else begin
                        wcnt--; bus.mem_addr_ok = 1'b0;
                    end
                end else begin
                    bus.mem_addr_ok = 1'b0;
                    chk("mem_idle_zero", 32'(|snap), 0);
                end
            end
        end
    end

    // response monitor
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.data_ok) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stale_data_ok: got data_ok=1 rdata=%h required no response", bus.rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", bus.rdata, e.rdata);
                    if (e.lat > 0) chk("data_ok_latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    // watchdog
    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: got no finish required finish before 2ms");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        int acc1, acc2, acc3, t;
        logic w, tlb;
        reset = 1'b1;
        bus.req = 1'b1; bus.wr = 1'b0; bus.tlb_ex = 1'b0; bus.wstrb = 4'h0; bus.size = 3'd0;
        bus.offset = '0; bus.index = '0; bus.tag = '0; bus.wdata = '0; bus.iscache = 1'b0;
        repeat (3) @(negedge clk);
        // reset state, with req held high
        chk("rst_addr_ok", 32'(bus.addr_ok), 0);
        chk("rst_data_ok", 32'(bus.data_ok), 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        bus.req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // single load, zero-wait memory
        issue(1'b0, 1'b0, 32'hBFC0_0010, 4'hF, 3'd2, 32'h0, 32'h1234_5678, 3, 1, t);
        drain(50);
        // single store
        issue(1'b1, 1'b0, 32'hA000_0002, 4'b0011, 3'd1, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 3, 1, t);
        drain(50);

        // full queue with 5-cycle address stall
        a_min = 5; a_max = 5;
        issue(1'b0, 1'b0, 32'h0000_0100, 4'hF, 3'd2, 32'h0, 32'h1, 0, 0, acc1);
        issue(1'b0, 1'b0, 32'h0000_0104, 4'hF, 3'd2, 32'h0, 32'h2, 0, 0, acc2);
        issue(1'b0, 1'b0, 32'h0000_0108, 4'hF, 3'd2, 32'h0, 32'h3, 0, 0, acc3);
        chk("full_accept2_gap", acc2 - acc1, 1);
        chk("full_accept3_gap", acc3 - acc1, 8);
        drain(100);
        a_min = 0; a_max = 0;

        // TLB exception between two loads; memory must see only A and B
        issue(1'b0, 1'b0, 32'h0000_0200, 4'hF, 3'd2, 32'h0, 32'hAAAA_0001, 3, 1, t);
        issue(1'b0, 1'b1, 32'h0000_0300, 4'hF, 3'd2, 32'h0, 32'hFFFF_FFFF, 0, 0, t);
        issue(1'b0, 1'b0, 32'h0000_0400, 4'hF, 3'd2, 32'h0, 32'hBBBB_0002, 0, 0, t);
        drain(50);
        // lone TLB exception: data_ok two cycles after accept
        issue(1'b1, 1'b1, 32'h0000_0500, 4'hF, 3'd2, 32'h5555_5555, 32'h0, 2, 0, t);
        drain(50);

        // reset while in WAIT with two entries queued
        d_min = 10; d_max = 10;
        issue(1'b0, 1'b0, 32'h0000_0600, 4'hF, 3'd2, 32'h0, 32'hC0C0_0001, 0, 0, t);
        issue(1'b0, 1'b0, 32'h0000_0604, 4'hF, 3'd2, 32'h0, 32'hC0C0_0002, 0, 0, t);
        @(posedge clk);
        #2;
        reset = 1'b1;
        bus.req = 1'b1;
        #1;
        chk("async_rst_addr_ok", 32'(bus.addr_ok), 0);
        chk("async_rst_data_ok", 32'(bus.data_ok), 0);
        chk("async_rst_rdata", bus.rdata, 0);
        chk("async_rst_mem_req", 32'(bus.mem_req), 0);
        chk("async_rst_mem_addr", bus.mem_addr, 0);
        exp_q.delete();
        plan_q.delete();
        bus.req = 1'b0;
        d_min = 0; d_max = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        issue(1'b0, 1'b0, 32'h0000_0700, 4'hF, 3'd2, 32'h0, 32'h7777_0007, 3, 1, t);
        drain(50);

        // random back-pressure on both memory handshakes
        a_min = 0; a_max = 4; d_min = 0; d_max = 4;
        for (int i = 0; i < 1000; i++) begin
            w   = 1'($urandom_range(1, 0));
            tlb = ($urandom_range(15, 0) == 0);
            issue(w, tlb, $urandom, 4'($urandom), 3'($urandom_range(2, 0)), $urandom, $urandom, 0, 0, t);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        drain(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dbus_uncached_responder.md
# dbus_uncached_responder

Responder end of the core's data-bus request/response protocol. It accepts load/store requests from the core's data port, queues them in order, and converts each one into a single uncached transaction on a simple memory-side `addr_ok`/`data_ok` port. Requests flagged with a TLB exception are answered without touching memory. It sits between the core and the memory/AXI bridge, as a drop-in for the data cache on uncached-only builds and for core bring-up.

## Interface
- `DEPTH`, default 2: request queue entries; legal values 1..8.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 1: core request valid.
- `wr` in 1: 1 = store, 0 = load.
- `wstrb` in 4: store byte enables.
- `size` in 3: 0 = byte, 1 = half, 2 = word.
- `offset` in 4, `index` in 8, `tag` in 20: request address, assembled as {tag, index, offset}.
- `wdata` in 32: store data.
- `iscache` in 1: ignored; every access is treated as uncached.
- `tlb_ex` in 1: the request carries an MMU exception.
- `addr_ok` out 1: request accepted this cycle.
- `data_ok` out 1: one-cycle response pulse.
- `rdata` out 32: load data, valid when `data_ok` is 1.
- `mem_req` out 1, `mem_wr` out 1, `mem_size` out 3, `mem_addr` out 32, `mem_wstrb` out 4, `mem_wdata` out 32: memory-side request.
- `mem_addr_ok` in 1, `mem_data_ok` in 1, `mem_rdata` in 32: memory-side handshake and response.

## Operation
- **Acceptance.**
  - `addr_ok = req && (count != DEPTH)`, where `count` is the registered queue occupancy.
  - On `req && addr_ok`, push {wr, tlb_ex, addr, wstrb, size, wdata} into the FIFO.
  - A pop in the same cycle does not free a slot for a push when the queue is full.
- **FSM states:** IDLE, WAIT.
- **IDLE with head valid and head.tlb_ex = 0:**
  - `mem_req = 1`; `mem_*` fields are driven from the head entry.
  - On `mem_addr_ok`, go to WAIT. The head stays in the queue.
- **IDLE with head valid and head.tlb_ex = 1:**
  - `mem_req = 0`.
  - Pop the head; next cycle `data_ok = 1` and `rdata = 0`.
  - Stay in IDLE.
- **WAIT:**
  - `mem_req = 0`.
  - On `mem_data_ok`: pop the head and register `data_ok <= 1`.
  - Register `rdata <= mem_rdata` for loads and `rdata <= 0` for stores.
  - Return to IDLE.
- **Ordering.**
  - Only one memory transaction is outstanding at a time.
  - Responses return strictly in acceptance order.
  - Stores also produce a `data_ok`.
- **Memory-side fields.**
  - `mem_addr` passes the address through unmodified; no alignment is applied.
  - `mem_wstrb` and `mem_wdata` pass through unmodified.
  - `mem_wstrb = 0` for loads.
- **Pointers.** FIFO pointers wrap modulo DEPTH. `count` is 0..DEPTH and is updated by push and pop independently.
- **Reset** (asynchronous, possible in any state):
  - Clears the FIFO and forces IDLE.
  - Drives `addr_ok`, `data_ok`, `mem_req` to 0 and `rdata` to 0.
  - An in-flight memory transaction is abandoned; the memory side must share the same reset.

## Timing
- **Reset values:** `data_ok = 0`, `rdata = 0`, `count = 0`, state IDLE. Combinational outputs are therefore 0.
- **Memory access, minimum latency** (accept at cycle T, zero-wait memory):
  - `mem_req` at T+1, with `mem_addr_ok` in the same cycle.
  - `mem_data_ok` at T+2.
  - `data_ok` at T+3.
- **TLB-exception request:** accept at T, `data_ok` at T+2, no memory activity.
- **`mem_req` hold:** once raised, `mem_req` stays high with stable fields until `mem_addr_ok`.
- **Throughput:** at best one memory response every 2 cycles. Acceptance continues while memory is busy, up to DEPTH entries.
- **Bus defaults:** `data_ok` is never high for two consecutive cycles for the same entry. `mem_*` data fields are 0 when `mem_req = 0`.

## Test plan
- **Single load.** Load to 0xBFC0_0010, size 2; memory returns 0x1234_5678 with zero wait.
  - Required: `addr_ok` at T, `mem_req` at T+1 with `mem_addr = 0xBFC00010`, `data_ok` at T+3 with `rdata = 0x12345678`.
- **Single store.** Store of 0xDEADBEEF with wstrb 4'b0011, size 1, to 0xA000_0002.
  - Required: `mem_wr = 1`, `mem_wstrb = 0011`, `mem_wdata = 0xDEADBEEF`, `mem_size = 1`; `data_ok` with `rdata = 0`.
- **Full queue with memory stall.** DEPTH = 2, `mem_addr_ok` held low 5 cycles, `req` held high.
  - Required: exactly 2 accepts, then `addr_ok = 0` until the first pop.
  - Three loads then return in issue order with data 1, 2, 3.
- **TLB exception between loads.** Load A, then a `tlb_ex` load, then load B.
  - Required: the memory side sees only A and B.
  - Three `data_ok` pulses in order, the middle one with `rdata = 0`.
- **Reset in WAIT.** Assert `reset` asynchronously mid-cycle while in WAIT with 2 entries queued.
  - Required: all outputs drop to 0 immediately.
  - After release, one fresh load completes in 3 cycles; no stale `data_ok`.
- **Memory-side back-pressure.** Random `mem_addr_ok`/`mem_data_ok` delays of 0–4 cycles over 1000 random loads/stores.
  - Required: a scoreboard confirms in-order responses, correct `rdata`, and stable `mem_*` fields while `mem_req` is high awaiting `mem_addr_ok`.
